// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle 16-bit ALU: single-cycle ADD/SUB, 16-step shift-add MUL and restoring DIV.
// Optional divider enabled by defining SEQ_ALU_DIV_EN; otherwise ALUOP=11 returns 0 via the EXEC path.
module seq_alu (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_aluop,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_start,
  output logic [15:0] o_result,
  output logic        o_done,
  output logic        o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER, S_DONE} state_t;

  state_t      r_state;
  logic [1:0]  r_op;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_acc;
  logic [3:0]  r_cnt;

  logic        w_iter_op;
  logic [15:0] w_exec_res;
  logic [15:0] w_mul_acc;

  // Multiplier bits are consumed LSB-first as r_b shifts right; r_a shifts left in step.
  assign w_mul_acc = r_acc + (r_b[0] ? r_a : 16'd0);

  always_comb begin
    w_exec_res = 16'd0;
    case (r_op)
      2'b00:   w_exec_res = r_a + r_b;
      2'b01:   w_exec_res = r_a - r_b;
      default: w_exec_res = 16'd0;
    endcase
  end

`ifdef SEQ_ALU_DIV_EN
  logic [15:0] r_rem;
  logic [16:0] w_rem_sh;
  logic [16:0] w_diff;
  logic        w_qbit;
  logic [15:0] w_rem_nx;
  logic [15:0] w_quo_nx;

  // Dividend bits enter the remainder MSB-first from r_a; a zero divisor always "fits", giving all ones.
  assign w_rem_sh  = {r_rem, r_a[15]};
  assign w_diff    = w_rem_sh - {1'b0, r_b};
  assign w_qbit    = ~w_diff[16];
  assign w_rem_nx  = w_qbit ? w_diff[15:0] : w_rem_sh[15:0];
  assign w_quo_nx  = {r_acc[14:0], w_qbit};
  assign w_iter_op = i_aluop[1];
`else
  assign w_iter_op = (i_aluop == 2'b10);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_op     <= 2'b00;
      r_a      <= 16'd0;
      r_b      <= 16'd0;
      r_acc    <= 16'd0;
      r_cnt    <= 4'd0;
      o_result <= 16'd0;
      o_done   <= 1'b0;
      o_busy   <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      r_rem    <= 16'd0;
`endif
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op    <= i_aluop;
            r_a     <= i_a;
            r_b     <= i_b;
            r_acc   <= 16'd0;
            r_cnt   <= 4'd0;
`ifdef SEQ_ALU_DIV_EN
            r_rem   <= 16'd0;
`endif
            o_busy  <= 1'b1;
            r_state <= w_iter_op ? S_ITER : S_EXEC;
          end
        end
        S_EXEC: begin
          o_result <= w_exec_res;
          o_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_ITER: begin
          r_cnt <= r_cnt + 4'd1;
          r_a   <= r_a << 1;
`ifdef SEQ_ALU_DIV_EN
          if (r_op[0]) begin
            r_acc <= w_quo_nx;
            r_rem <= w_rem_nx;
          end else begin
            r_acc <= w_mul_acc;
            r_b   <= r_b >> 1;
          end
`else
          r_acc <= w_mul_acc;
          r_b   <= r_b >> 1;
`endif
          if (r_cnt == 4'd15) begin
`ifdef SEQ_ALU_DIV_EN
            o_result <= r_op[0] ? w_quo_nx : w_mul_acc;
`else
            o_result <= w_mul_acc;
`endif
            o_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu: vector table, corner sequences, random ops vs arithmetic model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  aluop = 2'b00;
  logic [15:0] a = 16'd0;
  logic [15:0] b = 16'd0;
  logic        start = 1'b0;
  logic [15:0] o_result;
  logic        o_done;
  logic        o_busy;

  int tests = 0;
  int fails = 0;

  seq_alu dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_aluop  (aluop),
    .i_a      (a),
    .i_b      (b),
    .i_start  (start),
    .o_result (o_result),
    .o_done   (o_done),
    .o_busy   (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] model_res(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y);
    int unsigned p;
    case (op)
      2'd0: p = int'(x) + int'(y);
      2'd1: p = int'(x) - int'(y);
      2'd2: p = int'(x) * int'(y);
      default: begin
`ifdef SEQ_ALU_DIV_EN
        p = (y == 16'd0) ? 32'hFFFF : int'(x) / int'(y);
`else
        p = 0;
`endif
      end
    endcase
    return p[15:0];
  endfunction

  function automatic int model_lat(input logic [1:0] op);
`ifdef SEQ_ALU_DIV_EN
    return op[1] ? 16 : 1;
`else
    return (op == 2'd2) ? 16 : 1;
`endif
  endfunction

  // Launch one operation; hold keeps Start high until Done is seen, scramble randomizes inputs while in flight.
  task automatic do_op(input string nm, input logic [1:0] op, input logic [15:0] av, input logic [15:0] bv,
                       input bit hold, input bit scramble, input logic [15:0] exp_res, input int exp_lat);
    int lat;
    @(negedge clk);
    aluop = op; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    lat = 0;
    while (!o_done && lat < 40) begin
      chk($sformatf("%s busy_in_flight", nm), {31'd0, o_busy}, 32'd1);
      if (scramble) begin
        aluop = 2'($urandom); a = 16'($urandom); b = 16'($urandom); start = 1'($urandom);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    chk($sformatf("%s latency", nm), lat, exp_lat);
    chk($sformatf("%s result", nm), {16'd0, o_result}, {16'd0, exp_res});
    chk($sformatf("%s busy_in_done", nm), {31'd0, o_busy}, 32'd1);
    @(negedge clk);
    chk($sformatf("%s done_one_cycle", nm), {31'd0, o_done}, 32'd0);
    chk($sformatf("%s busy_after", nm), {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    chk($sformatf("%s no_second_op", nm), {31'd0, o_busy}, 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    int ndone;
    logic [1:0]  rop;
    logic [15:0] ra, rb;

    vecs[0] = '{2'd0, 16'h7FFF, 16'h0001, 16'h8000, 1};
    vecs[1] = '{2'd0, 16'hFFFF, 16'h0001, 16'h0000, 1};
    vecs[2] = '{2'd1, 16'h0000, 16'h0001, 16'hFFFF, 1};
    vecs[3] = '{2'd1, 16'h1234, 16'h0234, 16'h1000, 1};
    vecs[4] = '{2'd2, 16'd300,  16'd300,  16'h5F90, 16};
    vecs[5] = '{2'd2, 16'hFFFF, 16'hFFFF, 16'h0001, 16};
    vecs[6] = '{2'd2, 16'h1234, 16'h0000, 16'h0000, 16};
`ifdef SEQ_ALU_DIV_EN
    vecs[7] = '{2'd3, 16'd1000, 16'd7,    16'd142,  16};
    vecs[8] = '{2'd3, 16'd5,    16'd0,    16'hFFFF, 16};
    vecs[9] = '{2'd3, 16'hFFFF, 16'hFFFF, 16'h0001, 16};
`else
    vecs[7] = '{2'd3, 16'd1000, 16'd7,    16'h0000, 1};
    vecs[8] = '{2'd3, 16'd5,    16'd0,    16'h0000, 1};
    vecs[9] = '{2'd3, 16'hFFFF, 16'hFFFF, 16'h0000, 1};
`endif

    #1 rst = 1'b1;
    #2;
    chk("reset result", {16'd0, o_result}, 32'd0);
    chk("reset done", {31'd0, o_done}, 32'd0);
    chk("reset busy", {31'd0, o_busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, 1'b0, vecs[i].res, vecs[i].lat);

    do_op("sub_hold", 2'd1, 16'd3, 16'd5, 1'b0, 1'b0, 16'hFFFE, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("sub_hold idle%0d result", i), {16'd0, o_result}, 32'h0000FFFE);
      chk($sformatf("sub_hold idle%0d done", i), {31'd0, o_done}, 32'd0);
    end

    do_op("mul_scramble", 2'd2, 16'd300, 16'd300, 1'b0, 1'b1, 16'h5F90, 16);

    @(negedge clk);
    aluop = 2'd2; a = 16'd300; b = 16'd300; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort result", {16'd0, o_result}, 32'd0);
    chk("abort busy", {31'd0, o_busy}, 32'd0);
    chk("abort done", {31'd0, o_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_done) ndone++;
    end
    chk("abort no_done_pulse", ndone, 0);
    do_op("post_reset_add", 2'd0, 16'd2, 16'd2, 1'b0, 1'b0, 16'd4, 1);

    @(negedge clk);
    aluop = 2'd0; a = 16'd1; b = 16'd1; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("b2b cyc%0d done", i), {31'd0, o_done}, {31'd0, (i % 3) == 1});
      if ((i % 3) == 1) chk($sformatf("b2b cyc%0d result", i), {16'd0, o_result}, 32'd2);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("b2b busy_after", {31'd0, o_busy}, 32'd0);

    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 16'($urandom);
      rb  = (i % 7 == 0) ? 16'd0 : ((i % 3 == 0) ? 16'($urandom_range(1, 20)) : 16'($urandom));
      do_op($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb, 1'($urandom), 1'b1, model_res(rop, ra, rb), model_lat(rop));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
